// File: rtl/cache_interface_types.sv
// Shared types for the dcache port / store drain slice.
//   cache_access_size_t : access width shared by loads, stores and the dcache
//   drain_state_t       : store_drain_unit FSM states
//   grant_t             : arbitration result produced by dcache_port_arb
package cache_interface_types;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } cache_access_size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2,
    FENCE = 2'd3
  } drain_state_t;

  typedef enum logic [1:0] {
    GNT_NONE  = 2'd0,
    GNT_LOAD  = 2'd1,
    GNT_STORE = 2'd2,
    GNT_FENCE = 2'd3
  } grant_t;

endpackage

// File: rtl/dcache_port_arb.sv
// dcache_port_arb: priority arbitration between a MEM-stage load and the store
// buffer tail, plus the consecutive-load streak counter that keeps stores from
// starving.
// Optional feature macro: STORE_DRAIN_FENCE_EN (fence request wins in IDLE).
// Ports:
//   clk_i, reset_ni    clock, async active-low reset
//   idle_i             FSM is in IDLE (grants only issued then)
//   sb_full_i          store buffer full
//   sb_empty_i         store buffer empty
//   ld_valid_i         load request
//   ld_sb_conflict_i   load overlaps a buffered store
//   fence_req_i        drain request
//   grant_o            grant type for this cycle
module dcache_port_arb
  import cache_interface_types::*;
#(
  parameter int unsigned MAX_LOAD_STREAK = 4
) (
  input  logic   clk_i,
  input  logic   reset_ni,
  input  logic   idle_i,
  input  logic   sb_full_i,
  input  logic   sb_empty_i,
  input  logic   ld_valid_i,
  input  logic   ld_sb_conflict_i,
  input  logic   fence_req_i,
  output grant_t grant_o
);

  localparam int unsigned STREAK_W = $clog2(MAX_LOAD_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LOAD_STREAK);

  logic [STREAK_W-1:0] streak_q, streak_d;

`ifndef STORE_DRAIN_FENCE_EN
  logic unused_fence_req;
  assign unused_fence_req = fence_req_i;
`endif

  always_comb begin
    grant_o = GNT_NONE;
    if (idle_i) begin
`ifdef STORE_DRAIN_FENCE_EN
      if (fence_req_i) grant_o = GNT_FENCE;
      else
`endif
      if (sb_full_i) grant_o = GNT_STORE;
      else if (ld_valid_i && ld_sb_conflict_i && !sb_empty_i) grant_o = GNT_STORE;
      else if (ld_valid_i && (streak_q < STREAK_MAX)) grant_o = GNT_LOAD;
      else if (!sb_empty_i) grant_o = GNT_STORE;
    end
  end

  // Streak only counts loads that overtake a non-empty buffer.
  always_comb begin
    streak_d = streak_q;
    if (sb_empty_i || (grant_o == GNT_STORE)) streak_d = '0;
    else if ((grant_o == GNT_LOAD) && (streak_q != STREAK_MAX)) streak_d = streak_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) streak_q <= '0;
    else           streak_q <= streak_d;
  end

endmodule

// File: rtl/store_drain_unit.sv
// store_drain_unit: owns the single dcache port. Loads from the MEM stage and
// store-buffer tail drains share it; loads win unless a store is forced (buffer
// full, load conflict, or load streak exhausted).
// Optional feature macro: STORE_DRAIN_FENCE_EN (fence_req_i drains the buffer
// and pulses fence_done_o; otherwise fence_req_i is ignored, fence_done_o = 0).
// Ports:
//   clk_i, reset_ni                       clock, async active-low reset
//   sb_addr_i/sb_data_i/sb_size_i         store buffer tail entry
//   sb_empty_i/sb_full_i                  store buffer status
//   sb_get_enable_o                       tail retires when high with dc_hit_i
//   ld_valid_i/ld_addr_i/ld_size_i        load request
//   ld_sb_conflict_i                      load overlaps a buffered store
//   ld_ready_o                            load accepted this cycle
//   ld_done_o/ld_data_o                   registered load result pulse
//   dc_addr_o/dc_wdata_o/dc_size_o        dcache request
//   dc_rd_o/dc_wr_o                       dcache read / write strobes
//   dc_hit_i/dc_rdata_i                   dcache completion / read data
//   fence_req_i/fence_done_o              drain request / completion pulse
module store_drain_unit
  import cache_interface_types::*;
#(
  parameter int unsigned ADDR_SIZE       = 32,
  parameter int unsigned WORD_SIZE       = 32,
  parameter int unsigned MAX_LOAD_STREAK = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic [ADDR_SIZE-1:0] sb_addr_i,
  input  logic [WORD_SIZE-1:0] sb_data_i,
  input  cache_access_size_t   sb_size_i,
  input  logic                 sb_empty_i,
  input  logic                 sb_full_i,
  output logic                 sb_get_enable_o,
  input  logic                 ld_valid_i,
  input  logic [ADDR_SIZE-1:0] ld_addr_i,
  input  cache_access_size_t   ld_size_i,
  input  logic                 ld_sb_conflict_i,
  output logic                 ld_ready_o,
  output logic                 ld_done_o,
  output logic [WORD_SIZE-1:0] ld_data_o,
  output logic [ADDR_SIZE-1:0] dc_addr_o,
  output logic [WORD_SIZE-1:0] dc_wdata_o,
  output cache_access_size_t   dc_size_o,
  output logic                 dc_rd_o,
  output logic                 dc_wr_o,
  input  logic                 dc_hit_i,
  input  logic [WORD_SIZE-1:0] dc_rdata_i,
  input  logic                 fence_req_i,
  output logic                 fence_done_o
);

  drain_state_t       state_q, state_d;
  drain_state_t       store_ret;
  grant_t             grant;
  logic [ADDR_SIZE-1:0] ld_addr_q;
  cache_access_size_t ld_size_q;
  logic               ld_latch;
  logic               ld_done_q;
  logic [WORD_SIZE-1:0] ld_data_q;

  dcache_port_arb #(
    .MAX_LOAD_STREAK(MAX_LOAD_STREAK)
  ) u_arb (
    .clk_i           (clk_i),
    .reset_ni        (reset_ni),
    .idle_i          (state_q == IDLE),
    .sb_full_i       (sb_full_i),
    .sb_empty_i      (sb_empty_i),
    .ld_valid_i      (ld_valid_i),
    .ld_sb_conflict_i(ld_sb_conflict_i),
    .fence_req_i     (fence_req_i),
    .grant_o         (grant)
  );

`ifdef STORE_DRAIN_FENCE_EN
  // Remembers that STORE was entered from FENCE so it returns there.
  logic fence_active_q, fence_active_d;

  always_comb begin
    fence_active_d = fence_active_q;
    if ((state_q == IDLE) && (state_d == FENCE)) fence_active_d = 1'b1;
    else if ((state_q == FENCE) && (state_d == IDLE)) fence_active_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) fence_active_q <= 1'b0;
    else           fence_active_q <= fence_active_d;
  end

  assign store_ret = fence_active_q ? FENCE : IDLE;
`else
  assign store_ret = IDLE;
`endif

  always_comb begin
    state_d         = state_q;
    ld_ready_o      = 1'b0;
    ld_latch        = 1'b0;
    sb_get_enable_o = 1'b0;
    dc_rd_o         = 1'b0;
    dc_wr_o         = 1'b0;
    dc_addr_o       = '0;
    dc_wdata_o      = '0;
    dc_size_o       = SIZE_BYTE;
    fence_done_o    = 1'b0;
    case (state_q)
      IDLE: begin
        case (grant)
          GNT_LOAD: begin
            state_d    = LOAD;
            ld_ready_o = 1'b1;
            ld_latch   = 1'b1;
          end
          GNT_STORE: state_d = STORE;
          GNT_FENCE: state_d = FENCE;
          default:   state_d = IDLE;
        endcase
      end
      LOAD: begin
        dc_rd_o   = 1'b1;
        dc_addr_o = ld_addr_q;
        dc_size_o = ld_size_q;
        if (dc_hit_i) state_d = IDLE;
      end
      STORE: begin
        dc_wr_o         = 1'b1;
        sb_get_enable_o = 1'b1;
        dc_addr_o       = sb_addr_i;
        dc_wdata_o      = sb_data_i;
        dc_size_o       = sb_size_i;
        if (dc_hit_i) state_d = store_ret;
      end
`ifdef STORE_DRAIN_FENCE_EN
      FENCE: begin
        if (sb_empty_i) begin
          fence_done_o = 1'b1;
          state_d      = IDLE;
        end else begin
          state_d = STORE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= IDLE;
      ld_addr_q <= '0;
      ld_size_q <= SIZE_BYTE;
      ld_done_q <= 1'b0;
      ld_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ld_done_q <= (state_q == LOAD) && dc_hit_i;
      if (ld_latch) begin
        ld_addr_q <= ld_addr_i;
        ld_size_q <= ld_size_i;
      end
      if ((state_q == LOAD) && dc_hit_i) ld_data_q <= dc_rdata_i;
    end
  end

  assign ld_done_o = ld_done_q;
  assign ld_data_o = ld_data_q;

endmodule

// File: tb/tb_store_drain_unit.sv
module tb_store_drain_unit;
  import cache_interface_types::*;

  logic               clk_i = 1'b0;
  logic               reset_ni;
  logic [31:0]        sb_addr_i, sb_data_i, ld_addr_i, dc_rdata_i;
  cache_access_size_t sb_size_i, ld_size_i, dc_size_o;
  logic               sb_empty_i, sb_full_i, sb_get_enable_o;
  logic               ld_valid_i, ld_sb_conflict_i, ld_ready_o, ld_done_o;
  logic [31:0]        ld_data_o, dc_addr_o, dc_wdata_o;
  logic               dc_rd_o, dc_wr_o, dc_hit_i, fence_req_i, fence_done_o;

  int checks = 0;
  int errors = 0;
  int retires = 0;

  always #5 clk_i = ~clk_i;

  store_drain_unit #(
    .ADDR_SIZE(32), .WORD_SIZE(32), .MAX_LOAD_STREAK(4)
  ) dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .sb_addr_i(sb_addr_i), .sb_data_i(sb_data_i), .sb_size_i(sb_size_i),
    .sb_empty_i(sb_empty_i), .sb_full_i(sb_full_i), .sb_get_enable_o(sb_get_enable_o),
    .ld_valid_i(ld_valid_i), .ld_addr_i(ld_addr_i), .ld_size_i(ld_size_i),
    .ld_sb_conflict_i(ld_sb_conflict_i), .ld_ready_o(ld_ready_o),
    .ld_done_o(ld_done_o), .ld_data_o(ld_data_o),
    .dc_addr_o(dc_addr_o), .dc_wdata_o(dc_wdata_o), .dc_size_o(dc_size_o),
    .dc_rd_o(dc_rd_o), .dc_wr_o(dc_wr_o), .dc_hit_i(dc_hit_i), .dc_rdata_i(dc_rdata_i),
    .fence_req_i(fence_req_i), .fence_done_o(fence_done_o)
  );

  // Counts entries actually retired by the store buffer.
  always @(posedge clk_i) if (reset_ni && sb_get_enable_o && dc_hit_i) retires++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    reset_ni = 1'b0;
    sb_addr_i = 32'h200; sb_data_i = 32'h5555_0000; sb_size_i = SIZE_WORD;
    sb_empty_i = 1'b1; sb_full_i = 1'b0;
    ld_valid_i = 1'b0; ld_addr_i = 32'h100; ld_size_i = SIZE_WORD; ld_sb_conflict_i = 1'b0;
    dc_hit_i = 1'b0; dc_rdata_i = '0; fence_req_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    reset_ni = 1'b1;
  endtask

  typedef struct {
    logic        full, empty, ldv, conf;
    logic        exp_ready, exp_rd, exp_wr;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[6];
  logic acc[12];
  logic exp_acc[12];
  int   n, sb_cnt, stores, dones, r0;
  logic ret;

  initial begin
    // full, empty, ld_valid, conflict -> ready (grant cycle), rd, wr, addr (next cycle)
    vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h200};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h100};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h100};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    for (int i = 0; i < 12; i++) exp_acc[i] = (i == 4) || (i == 9);

    // Reset state
    do_reset();
    #1;
    check("reset_ready", ld_ready_o, 0);
    check("reset_rd_wr", {dc_rd_o, dc_wr_o, sb_get_enable_o}, 0);
    check("reset_done", {ld_done_o, fence_done_o}, 0);
    check("reset_addr", dc_addr_o, 0);

    // Arbitration table
    for (int i = 0; i < 6; i++) begin
      do_reset();
      sb_full_i = vecs[i].full; sb_empty_i = vecs[i].empty;
      ld_valid_i = vecs[i].ldv; ld_sb_conflict_i = vecs[i].conf;
      #1;
      check($sformatf("vec%0d_ready", i), ld_ready_o, vecs[i].exp_ready);
      tick();
      check($sformatf("vec%0d_rd", i), dc_rd_o, vecs[i].exp_rd);
      check($sformatf("vec%0d_wr", i), dc_wr_o, vecs[i].exp_wr);
      check($sformatf("vec%0d_addr", i), dc_addr_o, vecs[i].exp_addr);
    end

    // Reset asserted mid-STORE with a miss outstanding
    do_reset();
    sb_empty_i = 1'b0;
    tick();
    check("t1_store_wr", {dc_wr_o, sb_get_enable_o}, 2'b11);
    r0 = retires;
    #2 reset_ni = 1'b0;
    #1;
    check("t1_async_clear", {dc_wr_o, sb_get_enable_o, dc_rd_o, ld_ready_o}, 0);
    check("t1_async_addr", dc_addr_o, 0);
    tick();
    check("t1_held_clear", {dc_wr_o, sb_get_enable_o, dc_rd_o}, 0);
    check("t1_no_retire", retires - r0, 0);
    reset_ni = 1'b1;

    // Single load, hit on first request cycle
    do_reset();
    ld_valid_i = 1'b1; ld_addr_i = 32'h100;
    #1;
    check("t2_ready_c0", ld_ready_o, 1);
    tick();
    ld_valid_i = 1'b0; dc_hit_i = 1'b1; dc_rdata_i = 32'hDEAD_BEEF;
    #1;
    check("t2_rd_c1", dc_rd_o, 1);
    check("t2_addr_c1", dc_addr_o, 32'h100);
    check("t2_done_c1", ld_done_o, 0);
    tick();
    dc_hit_i = 1'b0; dc_rdata_i = 32'h0;
    check("t2_done_c2", ld_done_o, 1);
    check("t2_data_c2", ld_data_o, 32'hDEAD_BEEF);
    check("t2_rd_c2", dc_rd_o, 0);
    tick();
    check("t2_done_c3", ld_done_o, 0);

    // Load streak: 2 buffered stores, continuous loads, all accesses hit
    do_reset();
    sb_cnt = 2; sb_empty_i = 1'b0; ld_valid_i = 1'b1; dc_hit_i = 1'b1;
    n = 0;
    for (int c = 0; c < 40 && n < 12; c++) begin
      ret = 1'b0;
      if (dc_rd_o) begin acc[n] = 1'b0; n++; end
      else if (dc_wr_o) begin acc[n] = 1'b1; n++; ret = 1'b1; end
      tick();
      if (ret) begin sb_cnt--; sb_empty_i = (sb_cnt == 0); end
    end
    check("t3_access_count", n, 12);
    for (int i = 0; i < 12; i++)
      if (i < n) check($sformatf("t3_access%0d_is_store", i), acc[i], exp_acc[i]);
    ld_valid_i = 1'b0; dc_hit_i = 1'b0;

    // Conflicting load with one buffered store
    do_reset();
    sb_empty_i = 1'b0; ld_valid_i = 1'b1; ld_sb_conflict_i = 1'b1; ld_addr_i = 32'h140;
    #1;
    check("t5_ready_held", ld_ready_o, 0);
    tick();
    check("t5_wr_miss0", {dc_wr_o, ld_ready_o}, 2'b10);
    tick();
    check("t5_wr_miss1", {dc_wr_o, ld_ready_o}, 2'b10);
    dc_hit_i = 1'b1;
    tick();
    dc_hit_i = 1'b0; sb_empty_i = 1'b1;
    #1;
    check("t5_ready_after", ld_ready_o, 1);
    tick();
    check("t5_rd", dc_rd_o, 1);
    check("t5_addr", dc_addr_o, 32'h140);

    // Store miss for 5 cycles, hit on the 6th
    do_reset();
    sb_empty_i = 1'b0; sb_addr_i = 32'h300; sb_data_i = 32'hCAFE_0001;
    r0 = retires;
    tick();
    for (int i = 0; i < 6; i++) begin
      dc_hit_i = (i == 5);
      check($sformatf("t6_wr_get_c%0d", i), {dc_wr_o, sb_get_enable_o}, 2'b11);
      check($sformatf("t6_addr_c%0d", i), dc_addr_o, 32'h300);
      check($sformatf("t6_data_c%0d", i), dc_wdata_o, 32'hCAFE_0001);
      check($sformatf("t6_size_c%0d", i), dc_size_o, SIZE_WORD);
      tick();
    end
    dc_hit_i = 1'b0; sb_empty_i = 1'b1;
    #1;
    check("t6_wr_released", dc_wr_o, 0);
    check("t6_one_retire", retires - r0, 1);

`ifdef STORE_DRAIN_FENCE_EN
    // Fence over 3 buffered entries
    do_reset();
    sb_cnt = 3; sb_empty_i = 1'b0; fence_req_i = 1'b1; dc_hit_i = 1'b1; ld_valid_i = 1'b1;
    stores = 0; dones = 0; n = 0;
    for (int c = 0; c < 20; c++) begin
      ret = 1'b0;
      if (dc_wr_o) begin stores++; ret = 1'b1; end
      if (fence_done_o) dones++;
      if (ld_ready_o && dones == 0) n++;
      tick();
      fence_req_i = 1'b0;
      if (ret) begin sb_cnt--; sb_empty_i = (sb_cnt == 0); end
    end
    check("fence_stores", stores, 3);
    check("fence_done_pulses", dones, 1);
    check("fence_loads_refused", n, 0);
`else
    // Without the feature the request is ignored
    do_reset();
    fence_req_i = 1'b1;
    dones = 0;
    for (int c = 0; c < 5; c++) begin
      if (fence_done_o) dones++;
      tick();
    end
    check("nofence_done_tied0", dones, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
